alu_reservation_station: RTL and testbench

- Tomasulo-style reservation station in front of a single ALU.
- Accepts one dispatched instruction per cycle and holds its operands.
- Entries waiting on a ROB tag capture the value when that tag is broadcast on the CDB.
- When all operands of an entry are present and the ALU is free, the entry is issued to the ALU and released.

---
 rtl/alu_reservation_station.sv | 172 +++++++++++++++++
 tb/tb_alu_reservation_station.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// Reservation station feeding one ALU: holds dispatched ops until both operands arrive (regfile/CDB).
// Latency: issue no earlier than one cycle after load/capture; backpressure: res_empty=0 refuses dispatch, alu_free=0 holds ready entries.
package tomasula_types;
    localparam int ROB_TAG_W = 3;

    typedef enum logic [2:0] {
        NOP       = 3'd0,
        ARITH     = 3'd1,
        ARITH_IMM = 3'd2,
        LOAD      = 3'd3,
        STORE     = 3'd4,
        BRANCH    = 3'd5,
        JAL       = 3'd6,
        LUI       = 3'd7
    } op_t;

    typedef struct packed {
        op_t                  op;
        logic [4:0]           src1_reg;
        logic                 src1_valid;
        logic [4:0]           src2_reg;
        logic                 src2_valid;
        logic [2:0]           funct3;
        logic                 funct7;
        logic [ROB_TAG_W-1:0] rd;
        logic [31:0]          imm;
    } ctrl_word_t;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    typedef struct packed {
        op_t                  op;
        logic [2:0]           funct3;
        logic                 funct7;
        logic [ROB_TAG_W-1:0] rd;
        logic [31:0]          imm;
        logic [31:0]          src1;
        logic [31:0]          src2;
    } alu_data_t;
endpackage

module alu_reservation_station
    import tomasula_types::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_word,
    input  ctrl_word_t       control_word,
    input  logic [31:0]      src1,
    input  logic [31:0]      src2,
    input  logic             rob_v1,
    input  logic [TAG_W-1:0] rob_tag1,
    input  logic             rob_v2,
    input  logic [TAG_W-1:0] rob_tag2,
    input  cdb_t             cdb,
    input  logic             alu_free,
    output alu_data_t        alu_data,
    output logic             start_exe,
    output logic             res_empty
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             vld;
        ctrl_word_t       cw;
        logic             rdy1;
        logic [TAG_W-1:0] tag1;
        logic [31:0]      val1;
        logic             rdy2;
        logic [TAG_W-1:0] tag2;
        logic [31:0]      val2;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           new_ent;
    logic [TAG_W-1:0] cdb_tag;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             rdy_found;
    logic [IDX_W-1:0] rdy_idx;
    logic             dispatch;

    assign cdb_tag  = TAG_W'(cdb.tag);
    assign dispatch = load_word && free_found;

    // Priority pick of the lowest free slot and the lowest fully-ready entry.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_q[i].vld && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_q[i].vld && ent_q[i].rdy1 && ent_q[i].rdy2 && !rdy_found) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
        end
    end

    assign res_empty = free_found;
    assign start_exe = alu_free && rdy_found;

    always_comb begin
        alu_data = '0;
        if (start_exe) begin
            alu_data.op     = ent_q[rdy_idx].cw.op;
            alu_data.funct3 = ent_q[rdy_idx].cw.funct3;
            alu_data.funct7 = ent_q[rdy_idx].cw.funct7;
            alu_data.rd     = ent_q[rdy_idx].cw.rd;
            alu_data.imm    = ent_q[rdy_idx].cw.imm;
            alu_data.src1   = ent_q[rdy_idx].val1;
            alu_data.src2   = ent_q[rdy_idx].val2;
        end
    end

    // A pending operand whose producer is broadcasting this very cycle is forwarded at dispatch.
    always_comb begin
        new_ent      = '0;
        new_ent.vld  = 1'b1;
        new_ent.cw   = control_word;
        new_ent.tag1 = rob_tag1;
        new_ent.tag2 = rob_tag2;
        new_ent.rdy1 = !rob_v1 || (rob_tag1 == cdb_tag);
        new_ent.rdy2 = !rob_v2 || (rob_tag2 == cdb_tag);
        new_ent.val1 = rob_v1 ? cdb.data : src1;
        new_ent.val2 = rob_v2 ? cdb.data : src2;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].vld && !ent_q[i].rdy1 && (ent_q[i].tag1 == cdb_tag)) begin
                ent_d[i].rdy1 = 1'b1;
                ent_d[i].val1 = cdb.data;
            end
            if (ent_q[i].vld && !ent_q[i].rdy2 && (ent_q[i].tag2 == cdb_tag)) begin
                ent_d[i].rdy2 = 1'b1;
                ent_d[i].val2 = cdb.data;
            end
            if (start_exe && (rdy_idx == IDX_W'(i))) begin
                ent_d[i].vld = 1'b0;
            end
            // The free slot is never the issuing slot, so dispatch and issue cannot collide.
            if (dispatch && (free_idx == IDX_W'(i))) begin
                ent_d[i] = new_ent;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized and directed bench for alu_reservation_station against a slot-array reference model.
module tb_alu_reservation_station;
    import tomasula_types::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             load_word;
    ctrl_word_t       control_word;
    logic [31:0]      src1, src2;
    logic             rob_v1, rob_v2;
    logic [TAG_W-1:0] rob_tag1, rob_tag2;
    cdb_t             cdb;
    logic             alu_free;
    alu_data_t        alu_data;
    logic             start_exe;
    logic             res_empty;

    always #5 clk = ~clk;

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n), .load_word(load_word), .control_word(control_word),
        .src1(src1), .src2(src2), .rob_v1(rob_v1), .rob_tag1(rob_tag1),
        .rob_v2(rob_v2), .rob_tag2(rob_tag2), .cdb(cdb), .alu_free(alu_free),
        .alu_data(alu_data), .start_exe(start_exe), .res_empty(res_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          vld;
        ctrl_word_t  cw;
        bit          r1, r2;
        int          t1, t2;
        logic [31:0] v1, v2;
    } m_ent_t;

    m_ent_t    m [DEPTH];
    logic      obs_start, obs_empty;
    alu_data_t obs_data;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_first_free();
        for (int i = 0; i < DEPTH; i++) if (!m[i].vld) return i;
        return -1;
    endfunction

    function automatic int m_pick_issue();
        if (!alu_free) return -1;
        for (int i = 0; i < DEPTH; i++) if (m[i].vld && m[i].r1 && m[i].r2) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) m[i].vld = 1'b0;
    endtask

    // Apply one clock edge's worth of station rules to the model.
    task automatic m_edge();
        int ff, ii;
        ff = m_first_free();
        ii = m_pick_issue();
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].vld && !m[i].r1 && m[i].t1 == int'(cdb.tag)) begin m[i].r1 = 1; m[i].v1 = cdb.data; end
            if (m[i].vld && !m[i].r2 && m[i].t2 == int'(cdb.tag)) begin m[i].r2 = 1; m[i].v2 = cdb.data; end
        end
        if (ii >= 0) m[ii].vld = 1'b0;
        if (load_word && ff >= 0) begin
            m[ff].vld = 1'b1;
            m[ff].cw  = control_word;
            m[ff].t1  = int'(rob_tag1);
            m[ff].t2  = int'(rob_tag2);
            m[ff].r1  = !rob_v1 || (rob_tag1 == cdb.tag);
            m[ff].r2  = !rob_v2 || (rob_tag2 == cdb.tag);
            m[ff].v1  = !rob_v1 ? src1 : cdb.data;
            m[ff].v2  = !rob_v2 ? src2 : cdb.data;
        end
    endtask

    // Check outputs mid-cycle against the model, then advance DUT and model by one edge.
    task automatic cycle();
        int        ii;
        logic      exp_empty;
        alu_data_t exp_data;
        @(negedge clk);
        exp_empty = (m_first_free() >= 0);
        ii        = m_pick_issue();
        exp_data  = '0;
        if (ii >= 0) begin
            exp_data.op     = m[ii].cw.op;
            exp_data.funct3 = m[ii].cw.funct3;
            exp_data.funct7 = m[ii].cw.funct7;
            exp_data.rd     = m[ii].cw.rd;
            exp_data.imm    = m[ii].cw.imm;
            exp_data.src1   = m[ii].v1;
            exp_data.src2   = m[ii].v2;
        end
        obs_start = start_exe;
        obs_empty = res_empty;
        obs_data  = alu_data;
        check("start_exe", 128'(obs_start), 128'(ii >= 0));
        check("res_empty", 128'(obs_empty), 128'(exp_empty));
        check("alu_data", 128'(obs_data), 128'(exp_data));
        @(posedge clk);
        if (reset_n) m_edge();
        else m_clear();
        #1;
    endtask

    task automatic set_idle();
        load_word    = 1'b0;
        control_word = '0;
        src1         = '0;
        src2         = '0;
        rob_v1       = 1'b0;
        rob_tag1     = '0;
        rob_v2       = 1'b0;
        rob_tag2     = '0;
        cdb.tag      = 3'd7;
        cdb.data     = '0;
        alu_free     = 1'b0;
    endtask

    task automatic set_cw(input op_t op, input logic [2:0] f3, input logic [2:0] rd, input logic [31:0] imm);
        control_word        = '0;
        control_word.op     = op;
        control_word.funct3 = f3;
        control_word.rd     = rd;
        control_word.imm    = imm;
    endtask

    initial begin
        logic [63:0] r;
        set_idle();
        m_clear();

        // Reset held for five cycles.
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rst_start", 128'(obs_start), 128'(0));
            check("rst_empty", 128'(obs_empty), 128'(1));
            check("rst_data", 128'(obs_data), 128'(0));
        end
        reset_n = 1'b1;

        // Operand 1 waits on tag 1.
        set_cw(ARITH, 3'b000, 3'd3, 32'h0);
        load_word = 1'b1; src1 = 32'd5; src2 = 32'd3; rob_v1 = 1'b1; rob_tag1 = 3'd1;
        cycle();
        load_word = 1'b0; rob_v1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("dep_wait", 128'(obs_start), 128'(0));
        end
        cdb.tag = 3'd1; cdb.data = 32'd2;
        cycle();
        cdb.tag = 3'd7; alu_free = 1'b1;
        cycle();
        check("dep_start", 128'(obs_start), 128'(1));
        check("dep_src1", 128'(obs_data.src1), 128'(2));
        check("dep_src2", 128'(obs_data.src2), 128'(3));
        check("dep_op", 128'(obs_data.op), 128'(ARITH));
        check("dep_rd", 128'(obs_data.rd), 128'(3));
        alu_free = 1'b0;
        cycle();
        check("dep_empty", 128'(obs_empty), 128'(1));

        // Ready at dispatch: issues the cycle after the load.
        set_cw(ARITH, 3'b111, 3'd5, 32'h0);
        load_word = 1'b1; src1 = 32'd7; src2 = 32'd9; alu_free = 1'b1;
        cycle();
        check("rdy_same_cycle", 128'(obs_start), 128'(0));
        load_word = 1'b0;
        cycle();
        check("rdy_start", 128'(obs_start), 128'(1));
        check("rdy_src1", 128'(obs_data.src1), 128'(7));
        check("rdy_src2", 128'(obs_data.src2), 128'(9));

        // Same-cycle CDB forwarding into operand 2.
        set_cw(ARITH, 3'b001, 3'd6, 32'h0);
        load_word = 1'b1; src1 = 32'd1; src2 = 32'h55; rob_v2 = 1'b1; rob_tag2 = 3'd4;
        cdb.tag = 3'd4; cdb.data = 32'hAA; alu_free = 1'b0;
        cycle();
        load_word = 1'b0; rob_v2 = 1'b0; cdb.tag = 3'd7; alu_free = 1'b1;
        cycle();
        check("fwd_start", 128'(obs_start), 128'(1));
        check("fwd_src2", 128'(obs_data.src2), 128'(32'hAA));

        // Fill every slot with a waiting entry, then try one more load.
        alu_free = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_cw(ARITH, 3'b000, 3'(i), 32'h0);
            load_word = 1'b1; rob_v1 = 1'b1; rob_tag1 = 3'(i); src2 = 32'(i);
            cycle();
        end
        set_cw(ARITH, 3'b000, 3'd6, 32'h0);
        load_word = 1'b1; rob_v1 = 1'b0; src1 = 32'hDEAD;
        cycle();
        check("full_empty", 128'(obs_empty), 128'(0));
        load_word = 1'b0; alu_free = 1'b1;
        cycle();
        check("full_no_overwrite", 128'(obs_start), 128'(0));
        cdb.tag = 3'd2; cdb.data = 32'h123; alu_free = 1'b0;
        cycle();
        cdb.tag = 3'd7; alu_free = 1'b1;
        cycle();
        check("full_start", 128'(obs_start), 128'(1));
        check("full_rd", 128'(obs_data.rd), 128'(2));
        check("full_src1", 128'(obs_data.src1), 128'(32'h123));
        alu_free = 1'b0;
        cycle();
        check("full_empty_back", 128'(obs_empty), 128'(1));

        // Reset while entries are pending: a later matching broadcast must not issue.
        reset_n = 1'b0;
        m_clear();
        #1;
        check("mid_rst_empty", 128'(res_empty), 128'(1));
        check("mid_rst_start", 128'(start_exe), 128'(0));
        cycle();
        reset_n = 1'b1;
        alu_free = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cdb.tag = 3'(i); cdb.data = 32'h77;
            cycle();
            check("mid_rst_noissue", 128'(obs_start), 128'(0));
        end

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            r = {$urandom, $urandom};
            control_word    = r[$bits(ctrl_word_t)-1:0];
            control_word.op = op_t'(3'($urandom_range(1, 7)));
            load_word = 1'($urandom_range(0, 1));
            src1      = $urandom;
            src2      = $urandom;
            rob_v1    = 1'($urandom_range(0, 1));
            rob_v2    = 1'($urandom_range(0, 1));
            rob_tag1  = 3'($urandom_range(0, 7));
            rob_tag2  = 3'($urandom_range(0, 7));
            cdb.tag   = 3'($urandom_range(0, 7));
            cdb.data  = $urandom;
            alu_free  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
